// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg : funct3 encodings, FSM states and size/alignment helpers for the LSU
// Rev 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [2:0] F3_B       = 3'b000;
    localparam logic [2:0] F3_H       = 3'b001;
    localparam logic [2:0] F3_W       = 3'b010;
    localparam logic [2:0] F3_D       = 3'b011;
    localparam logic [2:0] F3_BU      = 3'b100;
    localparam logic [2:0] F3_HU      = 3'b101;
    localparam logic [2:0] F3_WU      = 3'b110;
    localparam logic [2:0] F3_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

    function automatic logic aligned(input logic [2:0] off, input logic [1:0] size);
        case (size)
            2'd0:    aligned = 1'b1;
            2'd1:    aligned = (off[0] == 1'b0);
            2'd2:    aligned = (off[1:0] == 2'b00);
            default: aligned = (off == 3'b000);
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_merge.sv
// ============================================================================
// lsu_lane_merge : big-endian field extract/extend for loads, field merge for stores
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [63:0] dword,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic [63:0] store_data
);

    localparam logic [63:0] C_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic [6:0]  w_nbits;
    logic [6:0]  w_lane_sh;
    logic [63:0] w_low_mask;
    logic [63:0] w_top_mask;
    logic [63:0] w_shifted;
    logic [63:0] w_field;
    logic        w_sign;

    assign w_nbits    = {size_bytes(funct3[1:0]), 3'b000};
    assign w_lane_sh  = {1'b0, off, 3'b000};
    assign w_low_mask = C_ONES >> (7'd64 - w_nbits);
    assign w_top_mask = ~(C_ONES >> w_nbits);

    // Byte at offset 0 is the MSB, so shifting left by the offset puts the field at the top.
    assign w_shifted = dword << w_lane_sh;
    assign w_field   = w_shifted >> (7'd64 - w_nbits);
    assign w_sign    = w_shifted[63] & ~funct3[2];
    assign load_data = w_field | (w_sign ? ~w_low_mask : 64'd0);

    assign store_data = (dword & ~(w_top_mask >> w_lane_sh))
                      | (((wdata & w_low_mask) << (7'd64 - w_nbits)) >> w_lane_sh);

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// load_store_unit : RV64 load/store sequencer for a big-endian 64-bit data memory
// Rev 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_t        r_state;
    logic              r_write;
    logic [2:0]        r_funct3;
    logic [2:0]        r_off;
    logic [DATA_W-1:0] r_wdata;

    logic              w_illegal;
    logic [DATA_W-1:0] w_load_data;
    logic [DATA_W-1:0] w_store_data;

    assign w_illegal = (req_funct3 == F3_ILLEGAL)
                     | (req_write & req_funct3[2])
                     | ~aligned(req_addr[2:0], req_funct3[1:0]);

    // Fed straight from the memory so the result is registered at the end of RD.
    lsu_lane_merge u_lane_merge (
        .dword      (mem_read_data),
        .off        (r_off),
        .funct3     (r_funct3),
        .wdata      (r_wdata),
        .load_data  (w_load_data),
        .store_data (w_store_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_write        <= 1'b0;
            r_funct3       <= 3'b000;
            r_off          <= 3'b000;
            r_wdata        <= '0;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_write   <= req_write;
                        r_funct3  <= req_funct3;
                        r_off     <= req_addr[2:0];
                        r_wdata   <= req_wdata;
                        req_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
                            if (req_write && (req_funct3[1:0] == 2'b11)) begin
                                r_state        <= ST_WR;
                                mem_write      <= 1'b1;
                                mem_write_data <= req_wdata;
                            end else begin
                                r_state  <= ST_RD;
                                mem_read <= 1'b1;
                            end
                        end
                    end
                end
                ST_RD: begin
                    mem_read <= 1'b0;
                    if (r_write) begin
                        r_state        <= ST_WR;
                        mem_write      <= 1'b1;
                        mem_write_data <= w_store_data;
                    end else begin
                        r_state    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= w_load_data;
                    end
                end
                ST_WR: begin
                    mem_write  <= 1'b0;
                    r_state    <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
